// File: rtl/timer_capture_reader.sv
// -----------------------------------------------------------------------------
// timer_capture_reader
//
// Input-capture and CPU readback companion for the byte-loaded 16-bit
// timer/counter unit. An asynchronous event pin is synchronised and
// glitch-filtered. A selected edge of the filtered level snapshots the live
// timer count. The CPU reads either the live count or the capture register as
// two bytes. Reading the low byte latches the matching high byte into a
// shadow, so the pair is always coherent.
//
// Ports
//   CLK          system clock
//   CPU_Reset    asynchronous, active-high reset
//   TIMER_VALUE  live count from the timer/counter unit
//   CAPTURE_IN   external event pin, asynchronous to CLK
//   CAP_EN       capture enable (synchroniser and filter always run)
//   EDGE_SEL     00 none, 01 rising, 10 falling, 11 both
//   CAP_ACK      one-cycle strobe clearing CAP_FLAG / CAP_OVERRUN
//   RD_SRC       read source: 0 live TIMER_VALUE, 1 capture register
//   RD_LSB       read strobe, low byte (also loads the high-byte shadow)
//   RD_MSB       read strobe, high byte (returns the shadow)
//   RD_DATA      registered read data, holds between reads
//   RD_VALID     one-cycle pulse one cycle after an accepted strobe
//   CAP_FLAG     capture pending
//   CAP_OVERRUN  capture occurred while a previous one was still pending
// -----------------------------------------------------------------------------
module timer_capture_reader #(
    parameter int WIDTH       = 16,  // fixed: two byte lanes
    parameter int SYNC_STAGES = 2,   // 2..4
    parameter int FILTER_LEN  = 3    // 1..15
) (
    input  logic             CLK,
    input  logic             CPU_Reset,
    input  logic [WIDTH-1:0] TIMER_VALUE,
    input  logic             CAPTURE_IN,
    input  logic             CAP_EN,
    input  logic [1:0]       EDGE_SEL,
    input  logic             CAP_ACK,
    input  logic             RD_SRC,
    input  logic             RD_LSB,
    input  logic             RD_MSB,
    output logic [7:0]       RD_DATA,
    output logic             RD_VALID,
    output logic             CAP_FLAG,
    output logic             CAP_OVERRUN
);

    // The filter counter is sized for the largest legal FILTER_LEN (15).
    localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q,     sync_d;
    logic                   filt_q,     filt_d;
    logic [3:0]             cnt_q,      cnt_d;
    logic [WIDTH-1:0]       cap_q,      cap_d;
    logic                   flag_q,     flag_d;
    logic                   overrun_q,  overrun_d;
    logic [WIDTH-9:0]       shadow_q,   shadow_d;
    logic [7:0]             rd_data_q,  rd_data_d;
    logic                   rd_valid_q, rd_valid_d;

    // Combinational helpers
    logic             sync_lvl;
    logic             toggle;
    logic             rise;
    logic             fall;
    logic             qual_edge;
    logic             capture;
    logic [WIDTH-1:0] rd_sel;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], CAPTURE_IN};
        sync_lvl   = sync_q[SYNC_STAGES-1];
        filt_d     = filt_q;
        cnt_d      = '0;
        toggle     = 1'b0;
        cap_d      = cap_q;
        flag_d     = flag_q;
        overrun_d  = overrun_q;
        shadow_d   = shadow_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        // Filter: the level only moves after FILTER_LEN consecutive cycles of
        // disagreement; any agreeing sample discards the partial count.
        if (sync_lvl != filt_q) begin
            if (cnt_q == FILT_LAST) begin
                toggle = 1'b1;
                filt_d = ~filt_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end

        // An edge is the cycle on which the filtered level toggles; its
        // direction follows from the level before the toggle.
        rise      = toggle & ~filt_q;
        fall      = toggle &  filt_q;
        qual_edge = (rise & EDGE_SEL[0]) | (fall & EDGE_SEL[1]);
        capture   = CAP_EN & qual_edge;

        // A same-cycle ACK wins over the overrun but not over the new capture.
        if (capture) begin
            cap_d  = TIMER_VALUE;
            flag_d = 1'b1;
            if (CAP_ACK) begin
                overrun_d = 1'b0;
            end else if (flag_q) begin
                overrun_d = 1'b1;
            end
        end else if (CAP_ACK) begin
            flag_d    = 1'b0;
            overrun_d = 1'b0;
        end

        // Read path uses cap_q, so a coincident capture is not visible to the
        // read in the same cycle.
        rd_sel = RD_SRC ? cap_q : TIMER_VALUE;
        if (RD_LSB) begin
            rd_data_d  = rd_sel[7:0];
            shadow_d   = rd_sel[WIDTH-1:8];
            rd_valid_d = 1'b1;
        end else if (RD_MSB) begin
            rd_data_d  = shadow_q;
            rd_valid_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: every register, including the capture register and shadow, is
    // reset so readback is deterministic straight out of reset.
    always_ff @(posedge CLK or posedge CPU_Reset) begin
        if (CPU_Reset) begin
            sync_q     <= '0;
            filt_q     <= 1'b0;
            cnt_q      <= '0;
            cap_q      <= '0;
            flag_q     <= 1'b0;
            overrun_q  <= 1'b0;
            shadow_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            flag_q     <= flag_d;
            overrun_q  <= overrun_d;
            shadow_q   <= shadow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign RD_DATA     = rd_data_q;
    assign RD_VALID    = rd_valid_q;
    assign CAP_FLAG    = flag_q;
    assign CAP_OVERRUN = overrun_q;

endmodule

// File: doc/timer_capture_reader.md
Name: timer_capture_reader

Overview:
Input-capture and CPU readback companion to the byte-loaded 16-bit timer/counter unit. It watches an external asynchronous event pin and snapshots the live timer value on a selected edge. It returns the live or captured value to the CPU over the 8-bit data path. The two byte reads are atomic: reading the LSB latches the matching MSB.

Parameters:
WIDTH, 16, timer/capture width in bits; fixed at 16 (two byte lanes)
SYNC_STAGES, 2, flops in the CAPTURE_IN synchroniser; legal range 2..4
FILTER_LEN, 3, consecutive equal samples needed before the filtered level changes; legal range 1..15

Ports:
CLK  input  1  system clock
CPU_Reset  input  1  reset, asynchronous, active-high
TIMER_VALUE  input  16  live count from the timer/counter unit
CAPTURE_IN  input  1  external event pin, asynchronous to CLK
CAP_EN  input  1  capture enable
EDGE_SEL  input  2  00 none, 01 rising, 10 falling, 11 both
CAP_ACK  input  1  one-cycle strobe; clears CAP_FLAG and CAP_OVERRUN
RD_SRC  input  1  0 = live TIMER_VALUE, 1 = capture register
RD_LSB  input  1  one-cycle read strobe, low byte
RD_MSB  input  1  one-cycle read strobe, high byte
RD_DATA  output  8  registered read data
RD_VALID  output  1  one-cycle pulse, one cycle after any read strobe
CAP_FLAG  output  1  capture pending
CAP_OVERRUN  output  1  capture occurred while CAP_FLAG was already set

Behaviour:
- Reset: all outputs 0. Synchroniser, filtered level, filter counter, capture register and MSB shadow all reset to 0.
- Synchroniser: CAPTURE_IN passes through SYNC_STAGES flops. No other logic touches the raw pin.
- Filter:
  - A counter increments while the sync output differs from the filtered level and resets to 0 when they match.
  - When the counter reaches FILTER_LEN, the filtered level toggles and the counter clears.
  - Pulses shorter than FILTER_LEN cycles at the sync output are rejected.
- Edge and latency:
  - An edge is the clock edge on which the filtered level toggles; EDGE_SEL qualifies it as rising or falling.
  - Counting the first CLK edge that samples the new pin level as edge 1, the toggle occurs on edge SYNC_STAGES+FILTER_LEN (5 with defaults).
  - The capture register loads the TIMER_VALUE present just before that edge.
- Capture event (CAP_EN=1 and a qualified edge):
  - Capture register <= TIMER_VALUE; CAP_FLAG <= 1.
  - If CAP_FLAG was already 1 with no CAP_ACK in the same cycle: CAP_OVERRUN <= 1 and the newest value overwrites.
- CAP_ACK:
  - Without a capture in the same cycle: CAP_FLAG and CAP_OVERRUN <= 0.
  - With a capture in the same cycle: CAP_FLAG = 1, CAP_OVERRUN = 0, register holds the new value.
- CAP_EN=0: synchroniser and filter keep running; no captures; flags hold. Re-enabling does not replay past edges.
- Power-up edge: a pin that is high after reset yields a rising edge at edge SYNC_STAGES+FILTER_LEN, since the filtered level resets to 0.
- Read path:
  - RD_LSB: RD_DATA <= selected[7:0] and shadow <= selected[15:8], both taken in the same cycle from the RD_SRC selection.
  - RD_MSB: RD_DATA <= shadow. The MSB always pairs with the last LSB read, even if TIMER_VALUE, the capture register or RD_SRC have changed since.
  - RD_LSB and RD_MSB in the same cycle: the LSB read wins; the MSB strobe is ignored.
  - A capture in the same cycle as RD_LSB with RD_SRC=1: the read returns the pre-capture register contents.
  - RD_DATA holds its value between reads. RD_VALID pulses 1 cycle after each accepted strobe; back-to-back strobes give consecutive pulses.
- Reset mid-operation: state clears immediately; any partial filter count is discarded.
- No arithmetic wrap: values pass through unmodified; TIMER_VALUE=16'hFFFF→16'h0000 rollover is captured as seen.

Test Plan:
- Reset, CAPTURE_IN=0, EDGE_SEL=01, CAP_EN=1, TIMER_VALUE incrementing from 16'h1000 each cycle; raise pin at edge 1 -> capture at edge 5 holds value present before edge 5, CAP_FLAG=1; RD_SRC=1, RD_LSB then RD_MSB -> RD_DATA returns matching low then high byte, RD_VALID pulses twice.
- 2-cycle pin glitch with FILTER_LEN=3 -> no capture, CAP_FLAG stays 0. 3-cycle pulse -> capture occurs.
- Two qualified edges without CAP_ACK (values 16'h0123 then 16'h0456) -> register=16'h0456, CAP_OVERRUN=1. CAP_ACK -> both flags 0. CAP_ACK coincident with a capture -> CAP_FLAG=1, CAP_OVERRUN=0.
- RD_SRC=0, TIMER_VALUE=16'h12FF, RD_LSB -> RD_DATA=8'hFF. TIMER_VALUE then becomes 16'h1300, RD_MSB -> RD_DATA=8'h12 (shadow, not 8'h13).
- EDGE_SEL=11 with one high pulse -> two captures and CAP_OVERRUN=1. EDGE_SEL=00 -> none. CAP_EN=0 -> none, filter still tracks; re-enable -> no spurious capture.
- Assert CPU_Reset mid-filter-count and with CAP_FLAG=1 -> all outputs 0 immediately. After release, a held-high pin yields a rising-edge capture at edge 5.
